// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter
// Registered N-way arbiter. It has two selection policies, chosen at each load slot:
//   mode=0 : fixed priority, where the highest-index request wins.
//   mode=1 : round-robin, where the search starts at ptr and wraps at N.
// The chosen winner goes into output registers, one clock after req is sampled.
//
// Handshake (valid/ready): out_valid=1 means grant_idx/grant_onehot carry a
// grant. The consumer takes it on any rising edge where out_ready=1. While
// out_valid=1 and out_ready=0, every output and ptr stays frozen, whatever req
// does. A "load slot" is an edge with out_valid=0 or out_ready=1. Only at a
// load slot are req and mode sampled. At that slot the registers take either
// the new winner or, when req==0, an empty grant. An empty grant keeps
// grant_idx at its last value.
module prio_rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot
);

    // Registered state
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0] grant_onehot_q, grant_onehot_d;
    logic [W-1:0] ptr_q, ptr_d;

    // Selection intermediates
    logic         load_slot;
    logic         any_req;
    logic [W-1:0] fixed_idx;
    logic [N-1:0] rr_rot;
    logic [W-1:0] rr_off;
    logic [W:0]   rr_sum;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win_idx;
    logic [W-1:0] ptr_after_win;

    assign load_slot = !out_valid_q || out_ready;
    assign any_req   = |req;

    // Fixed priority: scan upward so the last set bit seen, the highest index, wins.
    always_comb begin
        fixed_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_idx = W'(i);
            end
        end
    end

    // Rotate req right by ptr, so bit k of rr_rot is requester (ptr+k) mod N.
    assign rr_rot = N'({req, req} >> ptr_q);

    // Round-robin: the lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        rr_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rr_rot[i]) begin
                rr_off = W'(i);
            end
        end
    end

    // Undo the rotation. The sum is below 2N, so a single conditional subtract wraps it at N.
    always_comb begin
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        if (rr_sum >= (W+1)'(N)) begin
            rr_sum = rr_sum - (W+1)'(N);
        end
        rr_idx = rr_sum[W-1:0];
    end

    // Pick the policy's winner and compute the pointer that follows it, wrapping at N and not at 2^W.
    always_comb begin
        win_idx       = mode ? rr_idx : fixed_idx;
        ptr_after_win = (win_idx == W'(N - 1)) ? '0 : win_idx + 1'b1;
    end

    // Next-state: load a new grant or an empty grant at a load slot, otherwise hold everything.
    always_comb begin
        out_valid_d    = out_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        ptr_d          = ptr_q;
        if (load_slot) begin
            if (any_req) begin
                out_valid_d    = 1'b1;
                grant_idx_d    = win_idx;
                grant_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                if (mode) begin
                    ptr_d = ptr_after_win;
                end
            end else begin
                out_valid_d    = 1'b0;
                grant_onehot_d = '0;
            end
        end
    end

    // State registers. Asynchronous reset drops any pending grant and rewinds ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            ptr_q          <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            ptr_q          <= ptr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// tb_prio_rr_arbiter
// Drives an 8-way and a 5-way arbiter in lockstep. The behavioural model keeps
// valid/index/pointer as plain integers and picks winners with modulo arithmetic.
module tb_prio_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;
  logic       ov8, ov5;
  logic [2:0] gi8, gi5;
  logic [7:0] go8;
  logic [4:0] go5;

  int n_checks = 0;
  int n_fail = 0;

  bit mv8, mv5;
  int mi8, mi5, mp8, mp5;

  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  prio_rr_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode), .out_ready(out_ready),
    .out_valid(ov8), .grant_idx(gi8), .grant_onehot(go8)
  );

  prio_rr_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .out_ready(out_ready),
    .out_valid(ov5), .grant_idx(gi5), .grant_onehot(go5)
  );

  // Every cycle: the one-hot output agrees with the index when valid, and is zero when idle.
  always @(negedge clk) begin
    n_checks++;
    if (ov8 ? (go8 !== (8'd1 << gi8)) : (go8 !== 8'd0)) begin
      n_fail++;
      $display("FAIL onehot8 t=%0t valid=%b idx=%0d onehot=%b", $time, ov8, gi8, go8);
    end
    n_checks++;
    if (ov5 ? (go5 !== (5'd1 << gi5)) : (go5 !== 5'd0)) begin
      n_fail++;
      $display("FAIL onehot5 t=%0t valid=%b idx=%0d onehot=%b", $time, ov5, gi5, go5);
    end
  end

  // ---------------- reference model ----------------
  function automatic int pick(input logic [63:0] r, input int n, input logic m, input int p);
    int w = -1;
    if (!m) begin
      for (int j = 0; j < n; j++) if (r[j]) w = j;
    end else begin
      for (int k = 0; k < n; k++) if (w < 0 && r[(p + k) % n]) w = (p + k) % n;
    end
    return w;
  endfunction

  task automatic model_step(inout bit v, inout int idx, inout int p,
                            input logic [63:0] r, input int n, input logic m, input logic rdy);
    int w;
    if (!v || rdy) begin
      if (r == 64'd0) begin
        v = 1'b0;
      end else begin
        w = pick(r, n, m, p);
        v = 1'b1;
        idx = w;
        if (m) p = (w + 1) % n;
      end
    end
  endtask

  task automatic model_reset();
    mv8 = 1'b0; mi8 = 0; mp8 = 0;
    mv5 = 1'b0; mi5 = 0; mp5 = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] r8, input logic [4:0] r5, input logic m, input logic rdy);
    req8 = r8; req5 = r5; mode = m; out_ready = rdy;
    @(posedge clk);
    model_step(mv8, mi8, mp8, {56'd0, r8}, 8, m, rdy);
    model_step(mv5, mi5, mp5, {59'd0, r5}, 5, m, rdy);
    #1;
  endtask

  task automatic do_reset();
    req8 = '0; req5 = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(8'hFF, 5'h1F, 1'b0, 1'b0);
    n_checks++;
    if (ov8 !== 1'b1 || gi8 !== 3'd7) begin
      n_fail++; $display("FAIL pre_reset_grant got valid=%b idx=%0d exp valid=1 idx=7", ov8, gi8);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid8 got=%b exp=0", ov8); end
    n_checks++;
    if (gi8 !== 3'd0) begin n_fail++; $display("FAIL reset_idx8 got=%0d exp=0", gi8); end
    n_checks++;
    if (go8 !== 8'd0) begin n_fail++; $display("FAIL reset_onehot8 got=%b exp=0", go8); end
    n_checks++;
    if (ov5 !== 1'b0) begin n_fail++; $display("FAIL reset_valid5 got=%b exp=0", ov5); end
    n_checks++;
    if (gi5 !== 3'd0) begin n_fail++; $display("FAIL reset_idx5 got=%0d exp=0", gi5); end
    n_checks++;
    if (go5 !== 5'd0) begin n_fail++; $display("FAIL reset_onehot5 got=%b exp=0", go5); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(8'h00, 5'h00, 1'b0, 1'b0);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL no_replay8 got valid=%b exp=0", ov8); end
  endtask

  task automatic test_fixed();
    logic [7:0] vec [3] = '{8'h00, 8'h16, 8'h81};
    int         exp_i [3] = '{0, 4, 7};
    bit         exp_v [3] = '{1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 3; t++) begin
      drive(vec[t], 5'h00, 1'b0, 1'b1);
      n_checks++;
      if (ov8 !== exp_v[t]) begin
        n_fail++; $display("FAIL fixed_valid req=%h got=%b exp=%b", vec[t], ov8, exp_v[t]);
      end
      if (exp_v[t]) begin
        n_checks++;
        if (gi8 !== 3'(exp_i[t]) || gi8 !== 3'(mi8)) begin
          n_fail++; $display("FAIL fixed_idx req=%h got=%0d exp=%0d", vec[t], gi8, exp_i[t]);
        end
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [2:0] e;
    do_reset();
    for (int k = 0; k < 9; k++) exp_q.push_back(3'(k % 8));
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 5'h00, 1'b1, 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (ov8 !== 1'b1 || gi8 !== e) begin
        n_fail++; $display("FAIL rr_fair step=%0d got valid=%b idx=%0d exp idx=%0d", k, ov8, gi8, e);
      end
    end
  endtask

  task automatic test_backpressure();
    drive(8'h08, 5'h00, 1'b0, 1'b1);
    n_checks++;
    if (ov8 !== 1'b1 || gi8 !== 3'd3) begin
      n_fail++; $display("FAIL bp_setup got valid=%b idx=%0d exp valid=1 idx=3", ov8, gi8);
    end
    for (int k = 0; k < 5; k++) begin
      drive(8'h80, 5'h00, 1'b0, 1'b0);
      n_checks++;
      if (ov8 !== 1'b1 || gi8 !== 3'd3 || go8 !== 8'h08) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got valid=%b idx=%0d onehot=%b exp 1/3/00001000", k, ov8, gi8, go8);
      end
    end
    drive(8'h80, 5'h00, 1'b0, 1'b1);
    n_checks++;
    if (ov8 !== 1'b1 || gi8 !== 3'd7) begin
      n_fail++; $display("FAIL bp_release got valid=%b idx=%0d exp valid=1 idx=7", ov8, gi8);
    end
  endtask

  task automatic test_mode_toggle();
    do_reset();
    drive(8'h20, 5'h00, 1'b1, 1'b1);
    n_checks++;
    if (gi8 !== 3'd5) begin n_fail++; $display("FAIL toggle_rr5 got=%0d exp=5", gi8); end
    drive(8'h41, 5'h00, 1'b0, 1'b1);
    n_checks++;
    if (gi8 !== 3'd6) begin n_fail++; $display("FAIL toggle_fixed got=%0d exp=6", gi8); end
    drive(8'h41, 5'h00, 1'b1, 1'b1);
    n_checks++;
    if (gi8 !== 3'd6) begin n_fail++; $display("FAIL toggle_rr_back got=%0d exp=6", gi8); end
    drive(8'h81, 5'h00, 1'b1, 1'b1);
    n_checks++;
    if (gi8 !== 3'd7) begin n_fail++; $display("FAIL toggle_ptr7 got=%0d exp=7", gi8); end
  endtask

  task automatic test_n5_wrap();
    int seq [4] = '{0, 4, 0, 4};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(8'h00, 5'b10001, 1'b1, 1'b1);
      n_checks++;
      if (ov5 !== 1'b1 || gi5 !== 3'(seq[k]) || gi5 > 3'd4) begin
        n_fail++; $display("FAIL n5_alt step=%0d got valid=%b idx=%0d exp=%0d", k, ov5, gi5, seq[k]);
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (ov5 !== 1'b0 || go5 !== 5'd0) begin
      n_fail++; $display("FAIL n5_async_rst got valid=%b onehot=%b exp 0/0", ov5, go5);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(8'h00, 5'b10001, 1'b1, 1'b1);
    n_checks++;
    if (ov5 !== 1'b1 || gi5 !== 3'd0) begin
      n_fail++; $display("FAIL n5_after_rst got valid=%b idx=%0d exp valid=1 idx=0", ov5, gi5);
    end
  endtask

  task automatic test_random();
    logic [7:0] r8;
    logic [4:0] r5;
    for (int k = 0; k < 400; k++) begin
      r8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      r5 = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
      drive(r8, r5, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
      n_checks++;
      if (ov8 !== mv8 || gi8 !== 3'(mi8) || go8 !== (mv8 ? (8'd1 << mi8) : 8'd0)) begin
        n_fail++; $display("FAIL rand8 cyc=%0d got %b/%0d/%b exp %b/%0d", k, ov8, gi8, go8, mv8, mi8);
      end
      n_checks++;
      if (ov5 !== mv5 || gi5 !== 3'(mi5) || go5 !== (mv5 ? (5'd1 << mi5) : 5'd0)) begin
        n_fail++; $display("FAIL rand5 cyc=%0d got %b/%0d/%b exp %b/%0d", k, ov5, gi5, go5, mv5, mi5);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_backpressure();
    test_mode_toggle();
    test_n5_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: number of request inputs; legal range 2..64.
REQ-002 SHALL have parameter W, default $clog2(N): width of the encoded grant index.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, N bits: request vector; bit i set means requester i wants service.
REQ-006 SHALL have port mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the current grant.
REQ-008 SHALL have port out_valid, output, 1 bit: grant registers hold a valid grant.
REQ-009 SHALL have port grant_idx, output, W bits: encoded index of the granted requester.
REQ-010 SHALL have port grant_onehot, output, N bits: one-hot form of grant_idx; all zero when out_valid=0.

Function
REQ-011 SHALL define "load slot": clk edge where out_valid=0 or out_ready=1.
REQ-012 SHALL sample req and mode only at a load slot; req changes at other times have no effect.
REQ-013 At a load slot with req==0: SHALL set out_valid=0 and grant_onehot=0; grant_idx holds its last value.
REQ-014 At a load slot with req!=0: SHALL set out_valid=1, load grant_idx and grant_onehot from the selected winner; latency req->grant is one clock.
REQ-015 In fixed mode (mode=0): SHALL select the highest-index set bit of req (bit N-1 is highest priority).
REQ-016 In round-robin mode (mode=1): SHALL search from index ptr upward (ptr, ptr+1, ..., N-1, 0, ..., ptr-1) and select the first set bit.
REQ-017 SHALL keep an internal pointer ptr, W bits, range 0..N-1.
REQ-018 On every grant load in round-robin mode: SHALL set ptr = (winner+1) mod N; wrap: winner N-1 gives ptr 0.
REQ-019 In fixed mode: SHALL hold ptr unchanged, so the round-robin position survives mode toggles.
REQ-020 While out_valid=1 and out_ready=0: SHALL hold out_valid, grant_idx, grant_onehot and ptr stable, even if the granted req bit drops.
REQ-021 With out_valid=1, out_ready=1 and req!=0 at the same edge: SHALL accept the old grant and load the new grant with no bubble cycle.
REQ-022 Only one req bit set: SHALL grant that bit in either mode, regardless of ptr.
REQ-023 Non-power-of-two N: grant_idx SHALL never exceed N-1; ptr wrap SHALL be at N, not 2^W.
REQ-024 grant_onehot SHALL always equal (1<<grant_idx) when out_valid=1; at most one bit set.

Reset
REQ-025 While rst_n=0: SHALL drive out_valid=0, grant_idx=0, grant_onehot=0 and ptr=0, asynchronously.
REQ-026 Reset asserted mid-handshake: SHALL discard the pending grant; no grant is replayed after release.
REQ-027 First rising edge of clk after rst_n rises: SHALL be a load slot.

Verification
REQ-028 Fixed priority, N=8, mode=0, out_ready=1: req=8'b0000_0000 -> out_valid=0; req=8'b0001_0110 -> grant_idx=4; req=8'b1000_0001 -> grant_idx=7; all one clock later.
REQ-029 Round-robin fairness, N=8, mode=1, req=8'hFF held, out_ready=1: grant_idx sequence 0,1,2,...,7,0 on consecutive clocks after reset.
REQ-030 Backpressure: grant idx 3 valid, out_ready=0 for 5 clocks while req changes to 8'h80 -> grant_idx stays 3 and out_valid stays 1; one clock after out_ready=1 -> grant_idx=7.
REQ-031 Mode toggle: round-robin grant 5 (ptr=6), then mode=0 with req=8'h41 -> grant 6; back to mode=1 with req=8'h41 -> grant 6 (ptr was still 6), then ptr=7.
REQ-032 N=5, mode=1, req=5'b10001: grants alternate 0,4,0,4 with no index above 4; async rst_n pulse mid-stream -> out_valid=0 immediately, then first grant is 0.
REQ-033 Bench SHALL check every cycle that grant_onehot==(1<<grant_idx) when out_valid=1, and that grant_onehot==0 when out_valid=0.
